// File: rtl/ifm_addr_pkg.sv
// ifm_addr_pkg: shared lane geometry and FSM state encoding for the IFM address generator
// LANES  - addresses emitted per group
// ADDR_W - width of one lane address
// LANE_W - width of the lane index
package ifm_addr_pkg;
  localparam int LANES  = 8;
  localparam int ADDR_W = 10;
  localparam int LANE_W = $clog2(LANES);
  typedef enum logic [1:0] {IDLE, GEN, HOLD} state_t;
endpackage

// File: rtl/ifm_window_walker.sv
// ifm_window_walker: raster walk over convolution window positions of one tile
// clock, rst_n         - clock, async active-low reset
// i_load               - clear position, latch row_step from i_load_stride*i_load_len
// i_step               - advance to the next window position
// i_ksize/i_stride     - latched kernel size and stride
// i_len/i_ht           - latched tile width and height
// o_addr               - row_base + x of the current window
// o_col_wrap           - current window is the last one of its row
// o_last_pixel         - current window is the last one of the tile
module ifm_window_walker
  import ifm_addr_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [2:0]        i_load_stride,
  input  logic [5:0]        i_load_len,
  input  logic [2:0]        i_ksize,
  input  logic [2:0]        i_stride,
  input  logic [5:0]        i_len,
  input  logic [5:0]        i_ht,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_col_wrap,
  output logic              o_last_pixel
);
  logic [5:0]        r_x;
  logic [5:0]        r_y;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_row_step;
  logic [6:0]        w_x_reach;
  logic [6:0]        w_y_reach;
  // 7-bit reach of the next window: stepping is legal while reach <= extent
  assign w_x_reach    = {1'b0, r_x} + {4'b0, i_stride} + {4'b0, i_ksize};
  assign w_y_reach    = {1'b0, r_y} + {4'b0, i_stride} + {4'b0, i_ksize};
  assign o_col_wrap   = w_x_reach > {1'b0, i_len};
  assign o_last_pixel = o_col_wrap && (w_y_reach > {1'b0, i_ht});
  assign o_addr       = r_row_base + {{(ADDR_W-6){1'b0}}, r_x};
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
      r_row_step <= '0;
    end else if (i_load) begin
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
      r_row_step <= {7'b0, i_load_stride} * {4'b0, i_load_len};
    end else if (i_step) begin
      r_x        <= o_col_wrap ? 6'd0 : r_x + {3'b0, i_stride};
      r_y        <= o_col_wrap ? r_y + {3'b0, i_stride} : r_y;
      r_row_base <= o_col_wrap ? r_row_base + r_row_step : r_row_base;
    end
  end
endmodule

// File: rtl/ifm_addr_gen.sv
// ifm_addr_gen: emits convolution window base addresses of one tile in groups of LANES
// clock, rst_n     - clock, async active-low reset
// tile_start       - start a tile (sampled in IDLE only)
// tile_continue    - release the held group (sampled in HOLD only)
// ksize, stride    - square kernel size and window stride
// tile_length/height - tile dimensions in pixels
// base_address     - lane i at [ADDR_W*i +: ADDR_W], lane 0 earliest
// base_addr_valid  - per-lane valid
// addr_gen_done    - current group complete and stable
// ifmap_end        - held group is the last of the tile
module ifm_addr_gen
  import ifm_addr_pkg::*;
(
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     tile_start,
  input  logic                     tile_continue,
  input  logic [2:0]               ksize,
  input  logic [2:0]               stride,
  input  logic [5:0]               tile_length,
  input  logic [5:0]               tile_height,
  output logic [LANES*ADDR_W-1:0]  base_address,
  output logic [LANES-1:0]         base_addr_valid,
  output logic                     addr_gen_done,
  output logic                     ifmap_end
);
  state_t                         r_state;
  state_t                         w_next;
  logic [2:0]                     r_ksize;
  logic [2:0]                     r_stride;
  logic [5:0]                     r_len;
  logic [5:0]                     r_ht;
  logic [LANES-1:0][ADDR_W-1:0]   r_lane_addr;
  logic [LANES-1:0]               r_valid;
  logic [LANE_W-1:0]              r_lane;
  logic                           r_done;
  logic                           r_end;
  logic                           w_bad;
  logic                           w_load;
  logic                           w_step;
  logic                           w_col_wrap;
  logic                           w_last_pixel;
  logic                           w_final;
  logic                           w_group_full;
  logic [ADDR_W-1:0]              w_addr;
  // parameters that leave no legal window position finish immediately
  assign w_bad        = ksize == 3'd0 || stride == 3'd0 ||
                        {3'b0, ksize} > tile_length || {3'b0, ksize} > tile_height;
  assign w_load       = r_state == IDLE && tile_start;
  assign w_step       = r_state == GEN;
  assign w_final      = w_col_wrap && w_last_pixel;
  assign w_group_full = r_lane == LANE_W'(LANES-1);
  ifm_window_walker u_walker (
    .clock         (clock),
    .rst_n         (rst_n),
    .i_load        (w_load),
    .i_step        (w_step),
    .i_load_stride (stride),
    .i_load_len    (tile_length),
    .i_ksize       (r_ksize),
    .i_stride      (r_stride),
    .i_len         (r_len),
    .i_ht          (r_ht),
    .o_addr        (w_addr),
    .o_col_wrap    (w_col_wrap),
    .o_last_pixel  (w_last_pixel)
  );
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = tile_start ? (w_bad ? HOLD : GEN) : IDLE;
      GEN:     w_next = (w_final || w_group_full) ? HOLD : GEN;
      HOLD:    w_next = tile_continue ? (r_end ? IDLE : GEN) : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_ksize     <= '0;
      r_stride    <= '0;
      r_len       <= '0;
      r_ht        <= '0;
      r_lane_addr <= '0;
      r_valid     <= '0;
      r_lane      <= '0;
      r_done      <= 1'b0;
      r_end       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (tile_start) begin
          r_ksize     <= ksize;
          r_stride    <= stride;
          r_len       <= tile_length;
          r_ht        <= tile_height;
          r_lane_addr <= '0;
          r_valid     <= '0;
          r_lane      <= '0;
          r_done      <= w_bad;
          r_end       <= w_bad;
        end
        GEN: begin
          r_lane_addr[r_lane] <= w_addr;
          r_valid[r_lane]     <= 1'b1;
          r_done              <= w_final || w_group_full;
          r_end               <= w_final;
          r_lane              <= (w_final || w_group_full) ? r_lane : r_lane + 1'b1;
        end
        HOLD: if (tile_continue) begin
          r_lane_addr <= '0;
          r_valid     <= '0;
          r_lane      <= '0;
          r_done      <= 1'b0;
          r_end       <= 1'b0;
        end
        default: ;
      endcase
    end
  end
  assign base_address    = r_lane_addr;
  assign base_addr_valid = r_valid;
  assign addr_gen_done   = r_done;
  assign ifmap_end       = r_end;
endmodule

// File: tb/tb_ifm_addr_gen.sv
// tb_ifm_addr_gen: directed self-checking bench for ifm_addr_gen
module tb_ifm_addr_gen;
  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        tile_start = 1'b0;
  logic        tile_continue = 1'b0;
  logic [2:0]  ksize = '0;
  logic [2:0]  stride = '0;
  logic [5:0]  tile_length = '0;
  logic [5:0]  tile_height = '0;
  logic [79:0] base_address;
  logic [7:0]  base_addr_valid;
  logic        addr_gen_done;
  logic        ifmap_end;
  int total = 0;
  int bad = 0;
  int exp_q[$];
  int g3_exp[8] = '{24, 25, 28, 29, 30, 31, 32, 33};
  int s2_exp[8] = '{0, 2, 4, 16, 18, 20, 32, 34};

  ifm_addr_gen dut (
    .clock           (clock),
    .rst_n           (rst_n),
    .tile_start      (tile_start),
    .tile_continue   (tile_continue),
    .ksize           (ksize),
    .stride          (stride),
    .tile_length     (tile_length),
    .tile_height     (tile_height),
    .base_address    (base_address),
    .base_addr_valid (base_addr_valid),
    .addr_gen_done   (addr_gen_done),
    .ifmap_end       (ifmap_end)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic int lane(input int i);
    return int'(base_address[10*i +: 10]);
  endfunction

  task automatic build_model(input int k, input int s, input int len, input int ht);
    exp_q.delete();
    for (int y = 0; y + k <= ht; y += s)
      for (int x = 0; x + k <= len; x += s)
        exp_q.push_back((y * len + x) % 1024);
  endtask

  task automatic start_tile(input int k, input int s, input int len, input int ht);
    ksize = 3'(k);
    stride = 3'(s);
    tile_length = 6'(len);
    tile_height = 6'(ht);
    tile_start = 1'b1;
    tick;
    tile_start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!addr_gen_done && cyc < 40) begin
      tick;
      cyc++;
    end
  endtask

  task automatic pulse_continue;
    tile_continue = 1'b1;
    tick;
    tile_continue = 1'b0;
  endtask

  task automatic async_clear;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tile_start = 1'b0;
    tile_continue = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    #12;
    total++; if (base_address !== 80'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", base_address); end
    total++; if (base_addr_valid !== 8'h00) begin bad++; $display("FAIL reset_valid got=%h exp=00", base_addr_valid); end
    total++; if (addr_gen_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", addr_gen_done); end
    total++; if (ifmap_end !== 1'b0) begin bad++; $display("FAIL reset_end got=%b exp=0", ifmap_end); end
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_28x28;
    int cyc, n, ecyc;
    build_model(3, 1, 28, 28);
    start_tile(3, 1, 28, 28);
    for (int g = 0; g < 85; g++) begin
      n = (g == 84) ? 4 : 8;
      ecyc = (g == 84) ? 4 : 8;
      wait_done(cyc);
      total++; if (cyc !== ecyc) begin bad++; $display("FAIL t28_latency g=%0d got=%0d exp=%0d", g, cyc, ecyc); end
      for (int i = 0; i < 8; i++) begin
        total++;
        if (lane(i) !== ((i < n) ? exp_q[g*8+i] : 0)) begin
          bad++; $display("FAIL t28_lane g=%0d lane=%0d got=%0d exp=%0d", g, i, lane(i), (i < n) ? exp_q[g*8+i] : 0);
        end
      end
      total++; if (base_addr_valid !== 8'((1 << n) - 1)) begin bad++; $display("FAIL t28_valid g=%0d got=%h exp=%h", g, base_addr_valid, 8'((1 << n) - 1)); end
      total++; if (ifmap_end !== (g == 84)) begin bad++; $display("FAIL t28_end g=%0d got=%b exp=%b", g, ifmap_end, g == 84); end
      if (g == 0)
        for (int i = 0; i < 8; i++) begin
          total++; if (lane(i) !== i) begin bad++; $display("FAIL t28_g0 lane=%0d got=%0d exp=%0d", i, lane(i), i); end
        end
      if (g == 3)
        for (int i = 0; i < 8; i++) begin
          total++; if (lane(i) !== g3_exp[i]) begin bad++; $display("FAIL t28_g3 lane=%0d got=%0d exp=%0d", i, lane(i), g3_exp[i]); end
        end
      if (g == 84) begin
        for (int i = 0; i < 4; i++) begin
          total++; if (lane(i) !== 722 + i) begin bad++; $display("FAIL t28_g84 lane=%0d got=%0d exp=%0d", i, lane(i), 722 + i); end
        end
        total++; if (base_addr_valid !== 8'h0F) begin bad++; $display("FAIL t28_g84_valid got=%h exp=0f", base_addr_valid); end
      end
      pulse_continue;
      total++; if (addr_gen_done !== 1'b0) begin bad++; $display("FAIL t28_done_drop g=%0d got=%b exp=0", g, addr_gen_done); end
    end
    total++; if (ifmap_end !== 1'b0 || base_addr_valid !== 8'h00 || base_address !== 80'd0) begin
      bad++; $display("FAIL t28_idle end=%b valid=%h addr=%h exp=0", ifmap_end, base_addr_valid, base_address);
    end
  endtask

  task automatic test_stride2;
    int cyc;
    start_tile(3, 2, 8, 8);
    wait_done(cyc);
    total++; if (cyc !== 8) begin bad++; $display("FAIL s2_latency got=%0d exp=8", cyc); end
    for (int i = 0; i < 8; i++) begin
      total++; if (lane(i) !== s2_exp[i]) begin bad++; $display("FAIL s2_g0 lane=%0d got=%0d exp=%0d", i, lane(i), s2_exp[i]); end
    end
    total++; if (base_addr_valid !== 8'hFF) begin bad++; $display("FAIL s2_g0_valid got=%h exp=ff", base_addr_valid); end
    total++; if (ifmap_end !== 1'b0) begin bad++; $display("FAIL s2_g0_end got=%b exp=0", ifmap_end); end
    pulse_continue;
    wait_done(cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL s2_g1_latency got=%0d exp=1", cyc); end
    total++; if (lane(0) !== 36) begin bad++; $display("FAIL s2_g1_lane0 got=%0d exp=36", lane(0)); end
    total++; if (base_addr_valid !== 8'h01) begin bad++; $display("FAIL s2_g1_valid got=%h exp=01", base_addr_valid); end
    total++; if (ifmap_end !== 1'b1) begin bad++; $display("FAIL s2_g1_end got=%b exp=1", ifmap_end); end
    pulse_continue;
    total++; if (addr_gen_done !== 1'b0 || ifmap_end !== 1'b0) begin bad++; $display("FAIL s2_idle done=%b end=%b exp=0", addr_gen_done, ifmap_end); end
  endtask

  task automatic test_invalid;
    int k_t[5]  = '{7, 0, 3, 5, 3};
    int s_t[5]  = '{1, 1, 0, 1, 1};
    int l_t[5]  = '{4, 8, 8, 4, 8};
    int h_t[5]  = '{4, 8, 8, 8, 2};
    for (int t = 0; t < 5; t++) begin
      start_tile(k_t[t], s_t[t], l_t[t], h_t[t]);
      total++; if (addr_gen_done !== 1'b1) begin bad++; $display("FAIL inv_done t=%0d got=%b exp=1", t, addr_gen_done); end
      total++; if (ifmap_end !== 1'b1) begin bad++; $display("FAIL inv_end t=%0d got=%b exp=1", t, ifmap_end); end
      total++; if (base_addr_valid !== 8'h00) begin bad++; $display("FAIL inv_valid t=%0d got=%h exp=00", t, base_addr_valid); end
      pulse_continue;
      total++; if (addr_gen_done !== 1'b0 || ifmap_end !== 1'b0) begin bad++; $display("FAIL inv_idle t=%0d done=%b end=%b exp=0", t, addr_gen_done, ifmap_end); end
    end
  endtask

  task automatic test_held_inputs;
    int cyc;
    ksize = 3'd3; stride = 3'd2; tile_length = 6'd8; tile_height = 6'd8;
    tile_start = 1'b1;
    tick;
    tile_continue = 1'b1;
    wait_done(cyc);
    tile_continue = 1'b0;
    total++; if (cyc !== 8) begin bad++; $display("FAIL held_latency got=%0d exp=8", cyc); end
    for (int i = 0; i < 8; i++) begin
      total++; if (lane(i) !== s2_exp[i]) begin bad++; $display("FAIL held_g0 lane=%0d got=%0d exp=%0d", i, lane(i), s2_exp[i]); end
    end
    tile_continue = 1'b1;
    tick;
    wait_done(cyc);
    tile_continue = 1'b0;
    total++; if (cyc !== 1 || lane(0) !== 36 || ifmap_end !== 1'b1) begin
      bad++; $display("FAIL held_g1 cyc=%0d lane0=%0d end=%b exp 1/36/1", cyc, lane(0), ifmap_end);
    end
    tile_continue = 1'b1;
    tick;
    tile_continue = 1'b0;
    total++; if (addr_gen_done !== 1'b0 || base_addr_valid !== 8'h00) begin bad++; $display("FAIL held_idle done=%b valid=%h exp=0", addr_gen_done, base_addr_valid); end
    wait_done(cyc);
    total++; if (cyc !== 9) begin bad++; $display("FAIL held_restart_latency got=%0d exp=9", cyc); end
    total++; if (lane(0) !== 0 || lane(1) !== 2 || base_addr_valid !== 8'hFF) begin
      bad++; $display("FAIL held_restart lane0=%0d lane1=%0d valid=%h exp 0/2/ff", lane(0), lane(1), base_addr_valid);
    end
    tile_start = 1'b0;
    async_clear;
  endtask

  task automatic test_async_reset;
    int cyc;
    start_tile(3, 1, 28, 28);
    wait_done(cyc);
    pulse_continue;
    wait_done(cyc);
    pulse_continue;
    tick;
    tick;
    total++; if (base_addr_valid !== 8'h03) begin bad++; $display("FAIL arst_pre_valid got=%h exp=03", base_addr_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (base_address !== 80'd0 || base_addr_valid !== 8'h00) begin bad++; $display("FAIL arst_clear addr=%h valid=%h exp=0", base_address, base_addr_valid); end
    total++; if (addr_gen_done !== 1'b0 || ifmap_end !== 1'b0) begin bad++; $display("FAIL arst_flags done=%b end=%b exp=0", addr_gen_done, ifmap_end); end
    rst_n = 1'b1;
    tick;
    start_tile(3, 1, 28, 28);
    wait_done(cyc);
    total++; if (cyc !== 8) begin bad++; $display("FAIL arst_restart_latency got=%0d exp=8", cyc); end
    total++; if (lane(0) !== 0 || lane(7) !== 7 || base_addr_valid !== 8'hFF) begin
      bad++; $display("FAIL arst_restart lane0=%0d lane7=%0d valid=%h exp 0/7/ff", lane(0), lane(7), base_addr_valid);
    end
    async_clear;
  endtask

  task automatic test_toggle_continue;
    int g, n;
    logic prev;
    g = 0;
    prev = 1'b0;
    build_model(3, 1, 28, 28);
    start_tile(3, 1, 28, 28);
    for (int c = 0; c < 3000; c++) begin
      tile_continue = ~tile_continue;
      tick;
      if (addr_gen_done && !prev) begin
        n = (g == 84) ? 4 : 8;
        for (int i = 0; i < 8; i++) begin
          total++;
          if (g >= 85 || lane(i) !== ((i < n) ? exp_q[g*8+i] : 0)) begin
            bad++; $display("FAIL tog_lane g=%0d lane=%0d got=%0d", g, i, lane(i));
          end
        end
        total++; if (ifmap_end !== (g == 84)) begin bad++; $display("FAIL tog_end g=%0d got=%b exp=%b", g, ifmap_end, g == 84); end
        g++;
      end
      prev = addr_gen_done;
      if (g >= 85 && !addr_gen_done) break;
    end
    tile_continue = 1'b0;
    total++; if (g !== 85) begin bad++; $display("FAIL tog_groups got=%0d exp=85", g); end
    total++; if (addr_gen_done !== 1'b0 || base_addr_valid !== 8'h00) begin bad++; $display("FAIL tog_idle done=%b valid=%h exp=0", addr_gen_done, base_addr_valid); end
  endtask

  initial begin
    test_reset;
    test_28x28;
    test_stride2;
    test_invalid;
    test_held_inputs;
    test_async_reset;
    test_toggle_continue;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
